// File: rtl/bus_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_xfer
//  Purpose  : Registered register-transfer bus with one-hot destination
//             strobes, narrow-source masking, sticky error and a transfer count.
//  Revision : 1.0
// ============================================================================
module bus_xfer #(
    parameter int                 BUS_W       = 24,
    parameter int                 N_SRC       = 16,
    parameter int                 N_DST       = 16,
    parameter int                 SEL_W       = 5,
    parameter logic [N_SRC-1:0]   NARROW_MASK = 16'h0070 | 16'h8000,
    parameter int                 CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC*BUS_W-1:0] src_data,
    input  logic                   xfer_valid,
    input  logic [SEL_W-1:0]       read_en,
    input  logic [SEL_W-1:0]       write_en,
    input  logic                   err_clr,
    output logic [BUS_W-1:0]       busout,
    output logic                   bus_valid,
    output logic [N_DST-1:0]       dst_we,
    output logic                   err,
    output logic [CNT_W-1:0]       xfer_count
);

    localparam logic [SEL_W-1:0] c_SRC_MAX   = SEL_W'(N_SRC);
    localparam logic [SEL_W-1:0] c_DST_MAX   = SEL_W'(N_DST);
    localparam logic [SEL_W-1:0] c_BCAST     = '1;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    logic [BUS_W-1:0] r_busout;
    logic             r_bus_valid;
    logic [N_DST-1:0] r_dst_we;
    logic             r_err;
    logic [CNT_W-1:0] r_xfer_count;

    logic             w_read_legal;
    logic             w_write_legal;
    logic             w_broadcast;
    logic             w_legal;
    logic             w_illegal;
    logic [BUS_W-1:0] w_sel_data;
    logic             w_sel_narrow;
    logic [BUS_W-1:0] w_bus_next;
    logic [N_DST-1:0] w_dst_next;

    assign w_broadcast   = (write_en == c_BCAST);
    assign w_read_legal  = (read_en != '0) && (read_en <= c_SRC_MAX);
    assign w_write_legal = w_broadcast || (write_en <= c_DST_MAX);
    assign w_legal       = xfer_valid && w_read_legal && w_write_legal;
    assign w_illegal     = xfer_valid && !(w_read_legal && w_write_legal);

    // Read code i+1 selects source i; narrow sources keep only their low byte.
    always_comb begin
        w_sel_data   = '0;
        w_sel_narrow = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (read_en == SEL_W'(i + 1)) begin
                w_sel_data   = src_data[i*BUS_W +: BUS_W];
                w_sel_narrow = NARROW_MASK[i];
            end
        end
    end

    assign w_bus_next = w_sel_narrow ? {{(BUS_W-8){1'b0}}, w_sel_data[7:0]} : w_sel_data;

    always_comb begin
        w_dst_next = '0;
        for (int j = 0; j < N_DST; j++) begin
            w_dst_next[j] = w_broadcast || (write_en == SEL_W'(j + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busout     <= '0;
            r_bus_valid  <= 1'b0;
            r_dst_we     <= '0;
            r_err        <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            r_bus_valid <= w_legal;
            r_dst_we    <= w_legal ? w_dst_next : '0;
            if (w_legal) begin
                r_busout <= w_bus_next;
                if (r_xfer_count != c_CNT_MAX) begin
                    r_xfer_count <= r_xfer_count + 1'b1;
                end
            end
            // A new illegal request outranks a concurrent clear.
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign busout     = r_busout;
    assign bus_valid  = r_bus_valid;
    assign dst_we     = r_dst_we;
    assign err        = r_err;
    assign xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_xfer
//  Purpose  : Directed self-checking bench for bus_xfer (default and 4-bit
//             counter instances driven in parallel).
//  Revision : 1.0
// ============================================================================
module tb_bus_xfer;

    localparam int BUS_W = 24;
    localparam int N_SRC = 16;
    localparam int N_DST = 16;
    localparam int SEL_W = 5;

    logic                   clk;
    logic                   rst;
    logic [N_SRC*BUS_W-1:0] src_data;
    logic                   xfer_valid;
    logic [SEL_W-1:0]       read_en;
    logic [SEL_W-1:0]       write_en;
    logic                   err_clr;

    logic [BUS_W-1:0]       busout;
    logic                   bus_valid;
    logic [N_DST-1:0]       dst_we;
    logic                   err;
    logic [15:0]            xfer_count;

    logic [BUS_W-1:0]       s_busout;
    logic                   s_bus_valid;
    logic [N_DST-1:0]       s_dst_we;
    logic                   s_err;
    logic [3:0]             s_xfer_count;

    int checks = 0;
    int errors = 0;

    bus_xfer dut (
        .clk        (clk),
        .rst        (rst),
        .src_data   (src_data),
        .xfer_valid (xfer_valid),
        .read_en    (read_en),
        .write_en   (write_en),
        .err_clr    (err_clr),
        .busout     (busout),
        .bus_valid  (bus_valid),
        .dst_we     (dst_we),
        .err        (err),
        .xfer_count (xfer_count)
    );

    bus_xfer #(.CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .src_data   (src_data),
        .xfer_valid (xfer_valid),
        .read_en    (read_en),
        .write_en   (write_en),
        .err_clr    (err_clr),
        .busout     (s_busout),
        .bus_valid  (s_bus_valid),
        .dst_we     (s_dst_we),
        .err        (s_err),
        .xfer_count (s_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one request, then sample 1 time unit after the capturing edge.
    task automatic req(input logic v, input logic [SEL_W-1:0] r,
                       input logic [SEL_W-1:0] w, input logic clr);
        xfer_valid = v;
        read_en    = r;
        write_en   = w;
        err_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [BUS_W-1:0] v);
        src_data[i*BUS_W +: BUS_W] = v;
    endtask

    task automatic chk_xfer(input string tag, input logic [BUS_W-1:0] bus,
                            input logic bv, input logic [N_DST-1:0] we,
                            input logic [15:0] cnt);
        chk({tag, ".busout"},     64'(busout),     64'(bus));
        chk({tag, ".bus_valid"},  64'(bus_valid),  64'(bv));
        chk({tag, ".dst_we"},     64'(dst_we),     64'(we));
        chk({tag, ".xfer_count"}, 64'(xfer_count), 64'(cnt));
    endtask

    initial begin
        rst        = 1'b1;
        xfer_valid = 1'b1;
        read_en    = 5'd1;
        write_en   = 5'd1;
        err_clr    = 1'b0;
        for (int i = 0; i < N_SRC; i++) set_src(i, BUS_W'($urandom));

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_xfer("reset", 24'h0, 1'b0, 16'h0, 16'd0);
        chk("reset.err", 64'(err), 64'd0);

        rst = 1'b0;
        for (int i = 0; i < N_SRC; i++) set_src(i, 24'h0);
        set_src(0,  24'hABCDEF);
        set_src(1,  24'h7A5A5A);
        set_src(2,  24'h13579B);
        set_src(4,  24'h123456);
        set_src(6,  24'hFEDCBA);
        set_src(15, 24'h89ABCD);

        for (int k = 0; k < 5; k++) req(1'b0, 5'd0, 5'd0, 1'b0);
        chk_xfer("idle", 24'h0, 1'b0, 16'h0, 16'd0);
        chk("idle.err", 64'(err), 64'd0);

        req(1'b1, 5'd1, 5'd3, 1'b0);
        chk_xfer("full_src0", 24'hABCDEF, 1'b1, 16'h0004, 16'd1);
        req(1'b1, 5'd5, 5'd1, 1'b0);
        chk_xfer("narrow_src4", 24'h000056, 1'b1, 16'h0001, 16'd2);

        req(1'b1, 5'd3, 5'd1, 1'b0);
        chk_xfer("b2b_1", 24'h13579B, 1'b1, 16'h0001, 16'd3);
        req(1'b1, 5'd7, 5'd2, 1'b0);
        chk_xfer("b2b_2", 24'h0000BA, 1'b1, 16'h0002, 16'd4);
        req(1'b1, 5'd16, 5'd3, 1'b0);
        chk_xfer("b2b_3", 24'h0000CD, 1'b1, 16'h0004, 16'd5);
        req(1'b0, 5'd2, 5'd2, 1'b0);
        chk_xfer("hold", 24'h0000CD, 1'b0, 16'h0000, 16'd5);

        req(1'b1, 5'd0, 5'd1, 1'b0);
        chk_xfer("ill_rd0", 24'h0000CD, 1'b0, 16'h0000, 16'd5);
        chk("ill_rd0.err", 64'(err), 64'd1);
        req(1'b1, 5'd17, 5'd1, 1'b0);
        chk_xfer("ill_rd17", 24'h0000CD, 1'b0, 16'h0000, 16'd5);
        chk("ill_rd17.err", 64'(err), 64'd1);
        req(1'b1, 5'd2, 5'd17, 1'b1);
        chk_xfer("ill_wr17_clr", 24'h0000CD, 1'b0, 16'h0000, 16'd5);
        chk("ill_wr17_clr.err", 64'(err), 64'd1);
        req(1'b0, 5'd0, 5'd0, 1'b1);
        chk("clr.err", 64'(err), 64'd0);
        req(1'b0, 5'd0, 5'd20, 1'b0);
        chk("ignored_sel.err", 64'(err), 64'd0);

        req(1'b1, 5'd2, 5'h1F, 1'b0);
        chk_xfer("broadcast", 24'h7A5A5A, 1'b1, 16'hFFFF, 16'd6);
        req(1'b1, 5'd1, 5'd0, 1'b0);
        chk_xfer("bus_only", 24'hABCDEF, 1'b1, 16'h0000, 16'd7);
        chk("sat.pre", 64'(s_xfer_count), 64'd7);

        for (int k = 0; k < 20; k++) req(1'b1, 5'd1, 5'd2, 1'b0);
        chk("sat.count4", 64'(s_xfer_count), 64'd15);
        chk("sat.count16", 64'(xfer_count), 64'd27);

        rst = 1'b1;
        req(1'b1, 5'd3, 5'd4, 1'b0);
        chk_xfer("rst_mid", 24'h0, 1'b0, 16'h0, 16'd0);
        chk("rst_mid.err", 64'(err), 64'd0);
        chk("rst_mid.sat", 64'(s_xfer_count), 64'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_xfer.md
Name: bus_xfer

Overview:
- Parametrised, registered successor to the processor's combinational register-transfer bus.
- Selects one of N_SRC source registers by encoded read select and drives the registered bus.
- Issues a one-cycle, one-hot write strobe to the selected destination in the same cycle.
- Adds transfer qualification, 8-bit zero-extension masking, broadcast writes, a sticky illegal-select error and a transfer counter.

Parameters:
BUS_W, 24, bus and source data width.
N_SRC, 16, number of sources; read select code i (1..N_SRC) selects source i-1.
N_DST, 16, number of destinations; write select code j (1..N_DST) strobes destination j-1.
SEL_W, 5, width of the read and write select codes; must satisfy 2^SEL_W-1 > max(N_SRC, N_DST).
NARROW_MASK, 16'h0070 | 16'h8000, N_SRC-bit mask; bit i=1 marks source i as 8-bit. Bus carries {zeros, src[7:0]}.
CNT_W, 16, transfer counter width.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
src_data  in  N_SRC*BUS_W  packed sources; source i occupies bits [i*BUS_W +: BUS_W].
xfer_valid  in  1  transfer request, sampled at clk edge.
read_en  in  SEL_W  encoded source select; 0 = none.
write_en  in  SEL_W  encoded destination select; 0 = none; all-ones = broadcast.
err_clr  in  1  clears sticky error.
busout  out  BUS_W  registered bus value.
bus_valid  out  1  busout updated by a legal transfer this cycle.
dst_we  out  N_DST  one-hot (or all-ones on broadcast) write strobe, one cycle.
err  out  1  sticky illegal-select flag.
xfer_count  out  CNT_W  saturating count of completed legal transfers.

Behaviour:
- Reset (rst=1 at edge): busout=0, bus_valid=0, dst_we=0, err=0, xfer_count=0. Reset overrides a concurrent request; any pending strobe is dropped.
- Legality:
  - read_en legal iff 1..N_SRC.
  - write_en legal iff 0, 1..N_DST, or all-ones.
  - read_en=0 with xfer_valid=1 is illegal.
- Legal request at edge T (xfer_valid=1):
  - busout <= selected source, masked per NARROW_MASK.
  - bus_valid <= 1.
  - dst_we <= onehot(write_en-1); all-ones if broadcast; 0 if write_en=0 (bus-only load).
  - Latency: 1 cycle. Destinations capture busout at edge T+1 while dst_we is high.
- Illegal request at edge T:
  - busout holds, bus_valid <= 0, dst_we <= 0, err <= 1.
  - xfer_count unchanged.
- No request (xfer_valid=0): busout holds its last value (no return to 0), bus_valid <= 0, dst_we <= 0.
- Back-to-back legal requests each produce their own one-cycle strobe paired with their own busout value. Throughput is 1 per cycle with no bubbles.
- read_en/write_en are ignored when xfer_valid=0 and raise no error.
- err_clr:
  - Clears err at the edge.
  - If an illegal request occurs in the same cycle, set wins (err=1).
- xfer_count:
  - Increments by 1 per legal request, bus-only loads included.
  - Saturates at 2^CNT_W-1; no wrap.
- Width rules:
  - Narrow sources place src[7:0] at busout[7:0]; upper bits are 0.
  - Full sources pass all BUS_W bits.
  - No sign extension.
- dst_we and bus_valid are never high in a cycle unless the preceding edge sampled a legal request.

Test Plan:
- Reset then idle: rst high 2 cycles with src_data random → busout=0, dst_we=0, err=0, xfer_count=0. Idle 5 cycles → all unchanged.
- Narrow vs full: source 0=24'hABCDEF full, source 4=24'h123456 narrow. Request read_en=1, write_en=3 → next cycle busout=24'hABCDEF, dst_we=16'h0004. Then read_en=5, write_en=1 → busout=24'h000056, dst_we=16'h0001.
- Back-to-back plus hold: three consecutive legal requests to destinations 1, 2, 3 → dst_we sequence 0001, 0002, 0004 paired with the matching busout each cycle. On the idle cycle after, busout holds the last value and dst_we=0.
- Illegal and clear: read_en=0 with xfer_valid=1 → err=1, busout unchanged, no strobe. Next, read_en=17 → err stays 1. err_clr concurrent with another illegal request → err=1. err_clr alone → err=0.
- Broadcast and bus-only load: write_en=5'h1F, read_en=2 → dst_we=16'hFFFF. write_en=0 → dst_we=0, busout updated, bus_valid=1, xfer_count+1.
- Counter saturation and reset mid-stream: CNT_W=4, 20 legal requests → xfer_count=15. rst asserted together with a legal request → all outputs 0 next cycle.
